// File: rtl/mem2bits4vec.sv
// Vector-load gather unit: reads 16 consecutive memory words and packs their low
// bytes into one 128-bit vector value, element 0 in the most significant byte.
module mem2bits4vec #(
    parameter int AW      = 32,
    parameter int STRIDE  = 1,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rd_data,
    output logic          busy,
    output logic          done,
    output logic [127:0]  ResultV
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [AW-1:0] ADDR_STEP = AW'(STRIDE);

    logic [1:0]         state_r;
    logic [AW-1:0]      mem_addr_r;
    logic               rd_en_r;
    logic               busy_r;
    logic               done_r;
    logic [3:0]         issue_cnt_r;
    logic [3:0]         cap_cnt_r;
    logic [MEM_LAT-1:0] vpipe_r;
    logic [127:0]       pack_r;
    logic [127:0]       result_r;
    logic               capture_s;
    logic [127:0]       pack_next_s;

    // Responses arrive strictly in issue order, so shifting each new byte in from
    // the bottom leaves element 0 at [127:120] after sixteen captures.
    assign capture_s   = vpipe_r[MEM_LAT-1];
    assign pack_next_s = {pack_r[119:0], mem_rd_data[7:0]};

    // Issue/capture FSM, valid pipe and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_addr_r  <= '0;
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            issue_cnt_r <= 4'd0;
            cap_cnt_r   <= 4'd0;
            vpipe_r     <= '0;
            pack_r      <= 128'd0;
            result_r    <= 128'd0;
        end else begin
            done_r     <= 1'b0;
            vpipe_r[0] <= rd_en_r;
            for (int i = 1; i < MEM_LAT; i++) begin
                vpipe_r[i] <= vpipe_r[i-1];
            end

            if (capture_s) begin
                pack_r    <= pack_next_s;
                cap_cnt_r <= cap_cnt_r + 4'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mem_addr_r  <= base_addr;
                        rd_en_r     <= 1'b1;
                        busy_r      <= 1'b1;
                        issue_cnt_r <= 4'd0;
                        cap_cnt_r   <= 4'd0;
                        pack_r      <= 128'd0;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_cnt_r == 4'd15) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        mem_addr_r  <= mem_addr_r + ADDR_STEP;
                        issue_cnt_r <= issue_cnt_r + 4'd1;
                    end
                end
                ST_DRAIN: begin
                    // The last capture publishes the full vector together with done.
                    if (capture_s && (cap_cnt_r == 4'd15)) begin
                        result_r <= pack_next_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en = rd_en_r;
    assign mem_addr  = mem_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign ResultV   = result_r;

endmodule

// File: tb/tb_mem2bits4vec.sv
// Scoreboard bench for mem2bits4vec: four instances cover word/byte stride,
// an 8-bit wrapping address space and a three-cycle memory latency.
module tb_mem2bits4vec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start_v [4];
    logic [31:0]  base_addr;
    logic         rd_en_v [4];
    logic [31:0]  addr_v  [4];
    logic [31:0]  rdata_v [4];
    logic         busy_v  [4];
    logic         done_v  [4];
    logic [127:0] res_v   [4];
    logic [7:0]   addr8;

    logic [31:0]  mem [logic [31:0]];
    logic [31:0]  exp_addr_q [$];
    logic [127:0] exp_res_q  [$];
    int           cur;
    int           checks;
    int           failures;
    logic         mon_en;
    logic [31:0]  mon_ea;
    logic [127:0] mon_er;

    mem2bits4vec #(.AW(32), .STRIDE(1), .MEM_LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .base_addr(base_addr),
        .mem_rd_en(rd_en_v[0]), .mem_addr(addr_v[0]), .mem_rd_data(rdata_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .ResultV(res_v[0]));

    mem2bits4vec #(.AW(32), .STRIDE(4), .MEM_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .base_addr(base_addr),
        .mem_rd_en(rd_en_v[1]), .mem_addr(addr_v[1]), .mem_rd_data(rdata_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .ResultV(res_v[1]));

    mem2bits4vec #(.AW(8), .STRIDE(1), .MEM_LAT(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .base_addr(base_addr[7:0]),
        .mem_rd_en(rd_en_v[2]), .mem_addr(addr8), .mem_rd_data(rdata_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .ResultV(res_v[2]));

    mem2bits4vec #(.AW(32), .STRIDE(1), .MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .base_addr(base_addr),
        .mem_rd_en(rd_en_v[3]), .mem_addr(addr_v[3]), .mem_rd_data(rdata_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .ResultV(res_v[3]));

    assign addr_v[2] = {24'd0, addr8};

    function automatic int stride_of(int g);
        return (g == 1) ? 4 : 1;
    endfunction

    function automatic int lat_of(int g);
        return (g == 3) ? 3 : 1;
    endfunction

    function automatic logic [31:0] rd_word(logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[23:0], a[7:0] ^ 8'h5A};
    endfunction

    function automatic logic [31:0] elem_addr(int g, logic [31:0] base, int i);
        logic [31:0] a;
        a = base + 32'(i * stride_of(g));
        if (g == 2) a = {24'd0, a[7:0]};
        return a;
    endfunction

    // Memory models: data appears LAT cycles after the read strobe, garbage otherwise.
    for (genvar g = 0; g < 4; g++) begin : g_mem
        localparam int LAT = (g == 3) ? 3 : 1;
        logic [31:0] pipe [4];
        always @(posedge clk) begin
            pipe[0] <= (rd_en_v[g] === 1'b1) ? rd_word(addr_v[g]) : $urandom;
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign rdata_v[g] = pipe[LAT-1];
    end

    // Scoreboard monitor for the instance under test.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en_v[cur] === 1'b1) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_read inst=%0d addr=%h expected no read", cur, addr_v[cur]);
                end else begin
                    mon_ea = exp_addr_q.pop_front();
                    if (addr_v[cur] !== mon_ea) begin
                        failures++;
                        $display("FAIL read_addr inst=%0d got=%h exp=%h", cur, addr_v[cur], mon_ea);
                    end
                end
            end
            if (done_v[cur] === 1'b1) begin
                checks++;
                if (exp_res_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done inst=%0d result=%h", cur, res_v[cur]);
                end else begin
                    mon_er = exp_res_q.pop_front();
                    if (res_v[cur] !== mon_er) begin
                        failures++;
                        $display("FAIL result inst=%0d got=%h exp=%h", cur, res_v[cur], mon_er);
                    end
                end
            end
        end
    end

    task automatic push_load(int g, logic [31:0] base);
        logic [127:0] r;
        logic [31:0]  a;
        logic [31:0]  w;
        r = 128'd0;
        for (int i = 0; i < 16; i++) begin
            a = elem_addr(g, base, i);
            exp_addr_q.push_back(a);
            w = rd_word(a);
            r[127 - 8*i -: 8] = w[7:0];
        end
        exp_res_q.push_back(r);
    endtask

    // Starts a load and returns the cycle count to done, or -1 on timeout.
    task automatic run_load(int g, logic [31:0] base, output int lat);
        int n;
        cur = g;
        base_addr = base;
        push_load(g, base);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        n = 1;
        while (n < 60 && done_v[g] !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        lat = (n < 60) ? n : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        base_addr = 32'h100;
        for (int g = 0; g < 4; g++) start_v[g] = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rd_en_v[g] !== 1'b0 || addr_v[g] !== 32'd0 || busy_v[g] !== 1'b0 ||
                done_v[g] !== 1'b0 || res_v[g] !== 128'd0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d rd_en=%b addr=%h busy=%b done=%b res=%h exp all zero",
                         g, rd_en_v[g], addr_v[g], busy_v[g], done_v[g], res_v[g]);
            end
        end
        rst = 1'b0;
        for (int g = 0; g < 4; g++) start_v[g] = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (rd_en_v[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_read inst=%0d rd_en=%b exp 0", g, rd_en_v[g]);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic check_load(string name, int g, int lat, logic [127:0] exp);
        checks++;
        if (lat !== 17 + lat_of(g)) begin
            failures++;
            $display("FAIL %s_latency got=%0d exp=%0d", name, lat, 17 + lat_of(g));
        end
        checks++;
        if (res_v[g] !== exp || busy_v[g] !== 1'b0) begin
            failures++;
            $display("FAIL %s_value res=%h busy=%b exp res=%h busy=0", name, res_v[g], busy_v[g], exp);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_load(0, 32'h100, lat);
        check_load("basic", 0, lat, 128'h101112131415161718191A1B1C1D1E1F);
        repeat (3) @(negedge clk);
        checks++;
        if (res_v[0] !== 128'h101112131415161718191A1B1C1D1E1F || exp_addr_q.size() != 0) begin
            failures++;
            $display("FAIL basic_hold res=%h pending_reads=%0d exp held value, 0 pending",
                     res_v[0], exp_addr_q.size());
        end
    endtask

    task automatic test_stride();
        int lat;
        run_load(1, 32'h400, lat);
        check_load("stride", 1, lat, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat;
        run_load(2, 32'hF8, lat);
        check_load("wrap", 2, lat, 128'h707172737475767778797A7B7C7D7E7F);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_busy_start();
        int n;
        int seen;
        cur = 0;
        base_addr = 32'h100;
        push_load(0, 32'h100);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 1;
        while (n < 60 && done_v[0] !== 1'b1) begin
            if (n == 5) begin
                start_v[0] = 1'b1;
                base_addr = 32'h200;
            end else begin
                start_v[0] = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check_load("busy_start", 0, (n < 60) ? n : -1, 128'h101112131415161718191A1B1C1D1E1F);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_v[0] === 1'b1 || rd_en_v[0] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || exp_res_q.size() != 0) begin
            failures++;
            $display("FAIL busy_start_single activity=%0d pending=%0d exp 0 0", seen, exp_res_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_load(0, 32'h300, lat);
        check_load("b2b_first", 0, lat, 128'h303132333435363738393A3B3C3D3E3F);
        base_addr = 32'h200;
        start_v[0] = 1'b1;
        @(negedge clk);
        run_load(0, 32'h100, lat);
        check_load("b2b_second", 0, lat, 128'h101112131415161718191A1B1C1D1E1F);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_rst_abort(int g);
        int n;
        int lat;
        int seen;
        cur = g;
        base_addr = 32'h100;
        push_load(g, 32'h100);
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        n = 1;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_addr_q.delete();
        exp_res_q.delete();
        checks++;
        if (rd_en_v[g] !== 1'b0 || busy_v[g] !== 1'b0 || done_v[g] !== 1'b0 || res_v[g] !== 128'd0) begin
            failures++;
            $display("FAIL rst_abort inst=%0d rd_en=%b busy=%b done=%b res=%h exp all zero",
                     g, rd_en_v[g], busy_v[g], done_v[g], res_v[g]);
        end
        run_load(g, 32'h300, lat);
        check_load("rst_reload", g, lat, 128'h303132333435363738393A3B3C3D3E3F);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_v[g] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_extra_done inst=%0d count=%0d exp 0", g, seen);
        end
    endtask

    task automatic test_latency3();
        int lat;
        run_load(3, 32'h200, lat);
        check_load("lat3", 3, lat, 128'h505152535455565758595A5B5C5D5E5F);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        cur = 0;
        mon_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[32'h100 + 32'(i)]     = {24'hABCDEF, 8'(8'h10 + i)};
            mem[32'h200 + 32'(i)]     = {24'h777777, 8'(8'h50 + i)};
            mem[32'h300 + 32'(i)]     = {24'h123456, 8'(8'h30 + i)};
            mem[32'h400 + 32'(4 * i)] = 32'hFFFFFFA0 + 32'(i);
            mem[32'((8'hF8 + i) % 256)] = {24'h00C0DE, 8'(8'h70 + i)};
        end
        test_reset();
        test_basic();
        test_stride();
        test_wrap();
        test_busy_start();
        test_back_to_back();
        test_rst_abort(0);
        test_latency3();
        test_rst_abort(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
